scr1_mem_arbiter: RTL and testbench

- Shares one single-port SCR1-memif memory between the core's imem and dmem ports.
- Sits between the SCR1 core top and the memory model.
- Round-robin arbitration with exactly one transaction outstanding at a time.
- A response-timeout watchdog returns an error to a requester whose transaction stalls, then discards the late response.

---
 rtl/scr1_mem_arbiter_if.sv | 20 ++
 rtl/scr1_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_scr1_mem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/scr1_mem_arbiter_if.sv
// SCR1-memif style request/response bundle. The master drives the request
// payload; the slave returns the accept strobe and the single-cycle response.
interface scr1_mem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req;
  logic              cmd;
  logic [1:0]        width;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              req_ack;
  logic [DWIDTH-1:0] rdata;
  logic [1:0]        resp;

  modport master (output req, cmd, width, addr, wdata,
                  input  req_ack, rdata, resp);
  modport slave  (input  req, cmd, width, addr, wdata,
                  output req_ack, rdata, resp);
endinterface

// File: rtl/scr1_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memif memory between imem and
// dmem, one transaction in flight, with a response watchdog and late-response drain.
module scr1_mem_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  scr1_mem_arbiter_if.slave   imem,
  scr1_mem_arbiter_if.slave   dmem,
  scr1_mem_arbiter_if.master  mem
);

  typedef enum logic [1:0] {ST_ARB, ST_HOLD, ST_WAIT, ST_DRAIN} state_t;

  localparam logic       PORT_I    = 1'b0;
  localparam logic       PORT_D    = 1'b1;
  localparam logic [1:0] RESP_IDLE = 2'd0;
  localparam logic [1:0] RESP_ER   = 2'd2;
  localparam logic [1:0] WIDTH_W   = 2'd2;
  localparam logic       CMD_RD    = 1'b0;
  localparam bit         TMO_EN    = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMO_EN ? TMR_W'(TIMEOUT - 1) : '0;

  state_t           state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             last_grant_reg, last_grant_next;
  logic [TMR_W-1:0] timer_reg, timer_next;

  logic              owner;
  logic              owner_req;
  logic              owner_ack;
  logic [1:0]        owner_resp;
  logic [DWIDTH-1:0] owner_rdata;

  // imem is always a word read, so its command/width/wdata carry no information.
  logic unused_imem;
  assign unused_imem = ^{imem.cmd, imem.width, imem.wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_ARB;
      owner_reg      <= PORT_I;
      last_grant_reg <= PORT_I;
      timer_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      timer_reg      <= timer_next;
    end
  end

  // In ARB the owner is recomputed every cycle; once HOLD/WAIT/DRAIN is entered it is frozen.
  always_comb begin
    owner = owner_reg;
    if (state_reg == ST_ARB) begin
      if (imem.req && dmem.req) owner = (last_grant_reg == PORT_I) ? PORT_D : PORT_I;
      else if (dmem.req)        owner = PORT_D;
      else                      owner = PORT_I;
    end
    owner_req = (owner == PORT_D) ? dmem.req : imem.req;
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    timer_next      = timer_reg;
    owner_ack       = 1'b0;
    owner_resp      = RESP_IDLE;
    owner_rdata     = '0;
    mem.req         = 1'b0;
    mem.cmd         = CMD_RD;
    mem.width       = 2'd0;
    mem.addr        = '0;
    mem.wdata       = '0;

    unique case (state_reg)
      ST_ARB, ST_HOLD: begin
        mem.req = owner_req;
        if (owner_req) begin
          if (owner == PORT_D) begin
            mem.cmd   = dmem.cmd;
            mem.width = dmem.width;
            mem.addr  = dmem.addr;
            mem.wdata = dmem.wdata;
          end else begin
            mem.width = WIDTH_W;
            mem.addr  = imem.addr;
          end
          owner_ack  = mem.req_ack;
          owner_next = owner;
          if (mem.req_ack) begin
            state_next      = ST_WAIT;
            last_grant_next = owner;
            timer_next      = '0;
          end else begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        // A response landing on the expiry cycle takes priority over the timeout.
        if (mem.resp != RESP_IDLE) begin
          owner_resp  = mem.resp;
          owner_rdata = mem.rdata;
          state_next  = ST_ARB;
        end else if (TMO_EN && (timer_reg == TMR_LAST)) begin
          owner_resp = RESP_ER;
          state_next = ST_DRAIN;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem.resp != RESP_IDLE) state_next = ST_ARB;
      end
      default: state_next = ST_ARB;
    endcase

    imem.req_ack = 1'b0;
    imem.resp    = RESP_IDLE;
    imem.rdata   = '0;
    dmem.req_ack = 1'b0;
    dmem.resp    = RESP_IDLE;
    dmem.rdata   = '0;
    if (owner == PORT_D) begin
      dmem.req_ack = owner_ack;
      dmem.resp    = owner_resp;
      dmem.rdata   = owner_rdata;
    end else begin
      imem.req_ack = owner_ack;
      imem.resp    = owner_resp;
      imem.rdata   = owner_rdata;
    end

    // Outputs are quiet for the whole reset pulse, not just after the next edge.
    if (!rst_n) begin
      imem.req_ack = 1'b0;
      imem.resp    = RESP_IDLE;
      imem.rdata   = '0;
      dmem.req_ack = 1'b0;
      dmem.resp    = RESP_IDLE;
      dmem.rdata   = '0;
      mem.req      = 1'b0;
      mem.cmd      = 1'b0;
      mem.width    = 2'd0;
      mem.addr     = '0;
      mem.wdata    = '0;
    end
  end

endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// Bench for scr1_mem_arbiter: per-cycle vector table for the single-transaction
// corners, then a scoreboarded round-robin run against a one-cycle memory model.
module tb_scr1_mem_arbiter;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scr1_mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) imem ();
  scr1_mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) dmem ();
  scr1_mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) mem ();

  scr1_mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(4), .TMR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .imem  (imem),
    .dmem  (dmem),
    .mem   (mem)
  );

  typedef struct {
    string        name;
    bit           rst;
    bit           ireq;
    logic [31:0]  iaddr;
    bit           dreq;
    bit           dcmd;
    logic [1:0]   dwidth;
    logic [31:0]  daddr;
    logic [31:0]  dwdata;
    bit           mack;
    logic [1:0]   mresp;
    logic [31:0]  mrdata;
    logic [137:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [67:0] sb[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input string n, input bit rst, input bit ireq, input logic [31:0] iaddr,
                     input bit dreq, input bit dcmd, input logic [1:0] dw, input logic [31:0] daddr,
                     input logic [31:0] dwdata, input bit mack, input logic [1:0] mresp,
                     input logic [31:0] mrdata, input bit e_iack, input logic [1:0] e_iresp,
                     input logic [31:0] e_irdata, input bit e_dack, input logic [1:0] e_dresp,
                     input logic [31:0] e_drdata, input bit e_mreq, input bit e_mcmd,
                     input logic [1:0] e_mw, input logic [31:0] e_maddr, input logic [31:0] e_mwdata);
    vec_t v;
    v.name = n; v.rst = rst; v.ireq = ireq; v.iaddr = iaddr;
    v.dreq = dreq; v.dcmd = dcmd; v.dwidth = dw; v.daddr = daddr; v.dwdata = dwdata;
    v.mack = mack; v.mresp = mresp; v.mrdata = mrdata;
    v.exp = {e_iack, e_iresp, e_irdata, e_dack, e_dresp, e_drdata,
             e_mreq, e_mcmd, e_mw, e_maddr, e_mwdata};
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [137:0] act, input logic [137:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", n, act, exp);
    end else begin
      $display("[%0t] %s ok", $time, n);
    end
  endtask

  function automatic logic [137:0] observed();
    return {imem.req_ack, imem.resp, imem.rdata, dmem.req_ack, dmem.resp, dmem.rdata,
            mem.req, mem.cmd, mem.width, mem.addr, mem.wdata};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          pend;
    logic [31:0] pdata;
    logic [67:0] got;
    logic [67:0] want;

    imem.req = 1'b0; imem.cmd = 1'b0; imem.width = 2'd0; imem.addr = Z; imem.wdata = Z;
    dmem.req = 1'b0; dmem.cmd = 1'b0; dmem.width = 2'd0; dmem.addr = Z; dmem.wdata = Z;
    mem.req_ack = 1'b0; mem.resp = 2'd0; mem.rdata = Z;

    //   name                rst ireq iaddr        dreq dcmd dw    daddr        dwdata        mack mresp mrdata         | iack iresp irdata      dack dresp drdata      mreq mcmd mw   maddr        mwdata
    add("reset_quiet",       L,  H,   32'h200,     H,   L,   2'd2, 32'h300,     Z,            H,   2'd1, 32'h1234,      L, 2'd0, Z,           L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("i_rd_req",          H,  H,   32'h200,     L,   L,   2'd0, Z,           Z,            H,   2'd0, Z,             H, 2'd0, Z,           L, 2'd0, Z,           H, L, 2'd2, 32'h200,     Z);
    add("i_rd_resp",         H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd1, 32'h13,        L, 2'd1, 32'h13,      L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("d_werr_req",        H,  L,   Z,           H,   L,   2'd3, 32'h44,      Z,            H,   2'd0, Z,             L, 2'd0, Z,           H, 2'd0, Z,           H, L, 2'd3, 32'h44,      Z);
    add("d_werr_resp",       H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd2, Z,             L, 2'd0, Z,           L, 2'd2, Z,           L, L, 2'd0, Z,           Z);
    add("arb_stray_resp",    H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd1, 32'hFFFFFFFF,  L, 2'd0, Z,           L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("hold_0",            H,  L,   Z,           H,   H,   2'd2, 32'h10,      32'hDEADBEEF, L,   2'd0, Z,             L, 2'd0, Z,           L, 2'd0, Z,           H, H, 2'd2, 32'h10,      32'hDEADBEEF);
    for (int k = 1; k < 5; k++)
      add($sformatf("hold_%0d", k),
                             H,  H,   32'h200,     H,   H,   2'd2, 32'h10,      32'hDEADBEEF, L,   2'd0, Z,             L, 2'd0, Z,           L, 2'd0, Z,           H, H, 2'd2, 32'h10,      32'hDEADBEEF);
    add("hold_ack",          H,  H,   32'h200,     H,   H,   2'd2, 32'h10,      32'hDEADBEEF, H,   2'd0, Z,             L, 2'd0, Z,           H, 2'd0, Z,           H, H, 2'd2, 32'h10,      32'hDEADBEEF);
    add("hold_wr_resp",      H,  H,   32'h200,     L,   L,   2'd0, Z,           Z,            L,   2'd1, Z,             L, 2'd0, Z,           L, 2'd1, Z,           L, L, 2'd0, Z,           Z);
    add("i_after_hold",      H,  H,   32'h200,     L,   L,   2'd0, Z,           Z,            H,   2'd0, Z,             H, 2'd0, Z,           L, 2'd0, Z,           H, L, 2'd2, 32'h200,     Z);
    add("i_after_hold_resp", H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd1, 32'h13,        L, 2'd1, 32'h13,      L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("tmo_req",           H,  L,   Z,           H,   L,   2'd2, 32'h80,      Z,            H,   2'd0, Z,             L, 2'd0, Z,           H, 2'd0, Z,           H, L, 2'd2, 32'h80,      Z);
    for (int k = 1; k < 4; k++)
      add($sformatf("tmo_wait_%0d", k),
                             H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd0, Z,             L, 2'd0, Z,           L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("tmo_expire",        H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd0, Z,             L, 2'd0, Z,           L, 2'd2, Z,           L, L, 2'd0, Z,           Z);
    add("drain_block",       H,  H,   32'h300,     L,   L,   2'd0, Z,           Z,            H,   2'd0, Z,             L, 2'd0, Z,           L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("drain_swallow",     H,  H,   32'h300,     L,   L,   2'd0, Z,           Z,            H,   2'd1, 32'hAAAAAAAA,  L, 2'd0, Z,           L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("post_drain_req",    H,  H,   32'h300,     L,   L,   2'd0, Z,           Z,            H,   2'd0, Z,             H, 2'd0, Z,           L, 2'd0, Z,           H, L, 2'd2, 32'h300,     Z);
    add("post_drain_resp",   H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd1, 32'h13,        L, 2'd1, 32'h13,      L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("race_req",          H,  L,   Z,           H,   L,   2'd2, 32'h84,      Z,            H,   2'd0, Z,             L, 2'd0, Z,           H, 2'd0, Z,           H, L, 2'd2, 32'h84,      Z);
    for (int k = 1; k < 4; k++)
      add($sformatf("race_wait_%0d", k),
                             H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd0, Z,             L, 2'd0, Z,           L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("race_resp_wins",    H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd1, 32'h77,        L, 2'd0, Z,           L, 2'd1, 32'h77,      L, L, 2'd0, Z,           Z);
    add("race_next_req",     H,  L,   Z,           H,   L,   2'd2, 32'h88,      Z,            H,   2'd0, Z,             L, 2'd0, Z,           H, 2'd0, Z,           H, L, 2'd2, 32'h88,      Z);
    add("race_next_resp",    H,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd1, 32'h1,         L, 2'd0, Z,           L, 2'd1, 32'h1,       L, L, 2'd0, Z,           Z);
    add("rst_wait_req",      H,  L,   Z,           H,   L,   2'd2, 32'h90,      Z,            H,   2'd0, Z,             L, 2'd0, Z,           H, 2'd0, Z,           H, L, 2'd2, 32'h90,      Z);
    add("rst_in_wait",       L,  L,   Z,           L,   L,   2'd0, Z,           Z,            L,   2'd1, 32'h5,         L, 2'd0, Z,           L, 2'd0, Z,           L, L, 2'd0, Z,           Z);
    add("rst_contend_d",     H,  H,   32'h200,     H,   L,   2'd2, 32'h94,      Z,            H,   2'd0, Z,             L, 2'd0, Z,           H, 2'd0, Z,           H, L, 2'd2, 32'h94,      Z);
    add("rst_contend_resp",  H,  H,   32'h200,     L,   L,   2'd0, Z,           Z,            L,   2'd1, 32'h9,         L, 2'd0, Z,           L, 2'd1, 32'h9,       L, L, 2'd0, Z,           Z);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst_n       = vecs[i].rst;
      imem.req    = vecs[i].ireq;  imem.addr  = vecs[i].iaddr;
      dmem.req    = vecs[i].dreq;  dmem.cmd   = vecs[i].dcmd;  dmem.width = vecs[i].dwidth;
      dmem.addr   = vecs[i].daddr; dmem.wdata = vecs[i].dwdata;
      mem.req_ack = vecs[i].mack;  mem.resp   = vecs[i].mresp; mem.rdata  = vecs[i].mrdata;
      @(negedge clk);
      check(vecs[i].name, observed(), vecs[i].exp);
    end

    // Round-robin run from a fresh reset: DMEM must win first, then strict alternation.
    @(posedge clk); #1;
    rst_n = 1'b0;
    imem.req = 1'b0; dmem.req = 1'b0; mem.req_ack = 1'b0; mem.resp = 2'd0; mem.rdata = Z;
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem.req = 1'b1; imem.addr = 32'h200;
    dmem.req = 1'b1; dmem.addr = 32'h300; dmem.cmd = 1'b0; dmem.width = 2'd2; dmem.wdata = Z;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) sb.push_back({2'd0, 32'h0, 2'd1, ~32'h300});
      else            sb.push_back({2'd1, ~32'h200, 2'd0, 32'h0});
    end
    pend  = 1'b0;
    pdata = Z;
    for (int c = 0; c < 24 && sb.size() > 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      mem.req_ack = 1'b1;
      mem.resp    = pend ? 2'd1 : 2'd0;
      mem.rdata   = pend ? pdata : Z;
      @(negedge clk);
      if (imem.resp != 2'd0 || dmem.resp != 2'd0) begin
        got  = {imem.resp, imem.rdata, dmem.resp, dmem.rdata};
        want = sb.pop_front();
        check($sformatf("rr_resp_%0d", 5 - sb.size()), {70'h0, got}, {70'h0, want});
      end
      pend  = mem.req && mem.req_ack;
      pdata = ~mem.addr;
    end
    check("rr_all_responses", 138'(sb.size()), 138'(0));

    @(posedge clk); #1;
    imem.req = 1'b0; dmem.req = 1'b0; mem.req_ack = 1'b0; mem.resp = 2'd0; mem.rdata = Z;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
